// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the sprite position path: scheduler states,
// position-memory word offsets and orientation codes.
package vga_ctrl_pkg;

  localparam int POS_W_DEFAULT = 12;

  localparam logic [1:0] WORD_X = 2'd0;
  localparam logic [1:0] WORD_Y = 2'd1;
  localparam logic [1:0] WORD_O = 2'd2;

  typedef enum logic [1:0] {
    ORIENT_RIGHT = 2'd0,
    ORIENT_LEFT  = 2'd1,
    ORIENT_UP    = 2'd2,
    ORIENT_DOWN  = 2'd3
  } orient_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_WR_X = 3'd2,
    ST_WR_Y = 3'd3,
    ST_WR_O = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set candidate at or after ptr, wrapping
// modulo NUM_REQ. Zero latency; no backpressure (pure function of its inputs).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int j;
    j      = 0;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && cand[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sprite_position_scheduler.sv
// Round-robin burst writer of sprite x/y/orientation into position memory, only in vblank.
// 4 cycles per sprite (scan + 3 writes); requesters hold req until their one-cycle grant.
module sprite_position_scheduler
  import vga_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int POS_W   = POS_W_DEFAULT,
  parameter int IDX_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vblank,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*POS_W-1:0] req_x,
  input  logic [NUM_REQ*POS_W-1:0] req_y,
  input  logic [NUM_REQ*2-1:0]     req_orient,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     mem_wren,
  output logic [IDX_W+1:0]         mem_wraddress,
  output logic [POS_W-1:0]         mem_data,
  output logic                     position_memory_updated,
  output logic                     busy
);

  state_t               state_q, state_d;
  logic                 vblank_d_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   serviced_q, serviced_d;
  logic                 wrote_any_q, wrote_any_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [POS_W-1:0]     y_q, y_d;
  logic [1:0]           o_q, o_d;

  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 wren_q, wren_d;
  logic [IDX_W+1:0]     addr_q, addr_d;
  logic [POS_W-1:0]     data_q, data_d;
  logic                 upd_q, upd_d;
  logic                 busy_q, busy_d;

  logic                 vblank_rise;
  logic [NUM_REQ-1:0]   cand;
  logic                 arb_found;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic [IDX_W-1:0]     arb_idx;

  assign vblank_rise = vblank & ~vblank_d_q;
  // Gating by vblank keeps a sprite from starting once blanking has ended.
  assign cand        = req & ~serviced_q & {NUM_REQ{vblank}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .cand   (cand),
    .ptr    (ptr_q),
    .found  (arb_found),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    serviced_d  = serviced_q;
    wrote_any_d = wrote_any_q;
    idx_d       = idx_q;
    y_d         = y_q;
    o_d         = o_q;
    grant_d     = '0;
    wren_d      = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    upd_d       = 1'b0;

    // Outputs are registered, so each state computes what the next state shows.
    case (state_q)
      ST_IDLE: begin
        serviced_d  = '0;
        wrote_any_d = 1'b0;
        if (vblank_rise) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (arb_found) begin
          idx_d       = arb_idx;
          y_d         = req_y[int'(arb_idx)*POS_W +: POS_W];
          o_d         = req_orient[int'(arb_idx)*2 +: 2];
          serviced_d  = serviced_q | arb_onehot;
          wrote_any_d = 1'b1;
          ptr_d       = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          grant_d     = arb_onehot;
          wren_d      = 1'b1;
          addr_d      = {arb_idx, WORD_X};
          data_d      = req_x[int'(arb_idx)*POS_W +: POS_W];
          state_d     = ST_WR_X;
        end else begin
          upd_d   = wrote_any_q;
          state_d = ST_DONE;
        end
      end
      ST_WR_X: begin
        wren_d  = 1'b1;
        addr_d  = {idx_q, WORD_Y};
        data_d  = y_q;
        state_d = ST_WR_Y;
      end
      ST_WR_Y: begin
        wren_d  = 1'b1;
        addr_d  = {idx_q, WORD_O};
        data_d  = {{(POS_W-2){1'b0}}, o_q};
        state_d = ST_WR_O;
      end
      ST_WR_O: state_d = ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      vblank_d_q  <= 1'b0;
      ptr_q       <= '0;
      serviced_q  <= '0;
      wrote_any_q <= 1'b0;
      idx_q       <= '0;
      y_q         <= '0;
      o_q         <= '0;
      grant_q     <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblank_d_q  <= vblank;
      ptr_q       <= ptr_d;
      serviced_q  <= serviced_d;
      wrote_any_q <= wrote_any_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      o_q         <= o_d;
      grant_q     <= grant_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      upd_q       <= upd_d;
      busy_q      <= busy_d;
    end
  end

  assign grant                   = grant_q;
  assign mem_wren                = wren_q;
  assign mem_wraddress           = addr_q;
  assign mem_data                = data_q;
  assign position_memory_updated = upd_q;
  assign busy                    = busy_q;

endmodule
